// File: rtl/boot_sram_if.sv
// Access port bundle for boot_sram: req/ready handshake with registered read data.
interface boot_sram_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ready;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;
   logic              init_done;

   modport master (output req, we, addr, wdata, input ready, rdata, rvalid, init_done);
   modport slave  (input req, we, addr, wdata, output ready, rdata, rvalid, init_done);
endinterface

// File: rtl/boot_sram.sv
// Single-port synchronous RAM that zero-fills itself after reset, optionally loads
// the built-in boot program, then serves req/ready accesses with a 1-cycle read.
module boot_sram #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 8,
   parameter bit          BOOT_EN   = 1'b1,
   parameter int unsigned BOOT_BASE = 2
) (
   input logic        clk,
   input logic        reset,
   boot_sram_if.slave bus
);
   localparam int unsigned DEPTH    = 2**ADDR_W;
   localparam int unsigned BOOT_LEN = 9;

   typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_IDLE} state_t;

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
   logic              r_ready, w_ready_nxt;
   logic              r_init_done, w_init_done_nxt;
   logic              r_rvalid, w_rvalid_nxt;
   logic [DATA_W-1:0] r_rdata;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_mem_we;
   logic              w_mem_re;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;

   function automatic logic [7:0] boot_byte(input logic [3:0] idx);
      case (idx)
         4'd0:    boot_byte = 8'h80;
         4'd1:    boot_byte = 8'h01;
         4'd2:    boot_byte = 8'h81;
         4'd3:    boot_byte = 8'h01;
         4'd4:    boot_byte = 8'h82;
         4'd5:    boot_byte = 8'h08;
         4'd6:    boot_byte = 8'h41;
         4'd7:    boot_byte = 8'h44;
         4'd8:    boot_byte = 8'h92;
         default: boot_byte = 8'h00;
      endcase
   endfunction

   // State register plus control flags that must clear on reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_CLEAR;
         r_ptr       <= '0;
         r_ready     <= 1'b0;
         r_init_done <= 1'b0;
         r_rvalid    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_ptr       <= w_ptr_nxt;
         r_ready     <= w_ready_nxt;
         r_init_done <= w_init_done_nxt;
         r_rvalid    <= w_rvalid_nxt;
      end
   end

   // Next state and the single memory port shared by init and user accesses
   always_comb begin
      w_state_nxt  = r_state;
      w_ptr_nxt    = r_ptr;
      w_rvalid_nxt = 1'b0;
      w_mem_we     = 1'b0;
      w_mem_re     = 1'b0;
      w_mem_addr   = r_ptr;
      w_mem_wdata  = '0;
      case (r_state)
         S_CLEAR: begin
            w_mem_we = 1'b1;
            if (r_ptr == ADDR_W'(DEPTH - 1)) begin
               w_ptr_nxt   = '0;
               w_state_nxt = BOOT_EN ? S_LOAD : S_IDLE;
            end else begin
               w_ptr_nxt = r_ptr + ADDR_W'(1);
            end
         end
         S_LOAD: begin
            w_mem_we    = 1'b1;
            w_mem_addr  = ADDR_W'(BOOT_BASE) + r_ptr;
            w_mem_wdata = DATA_W'(boot_byte(4'(r_ptr)));
            if (r_ptr == ADDR_W'(BOOT_LEN - 1)) begin
               w_ptr_nxt   = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_ptr_nxt = r_ptr + ADDR_W'(1);
            end
         end
         S_IDLE: begin
            if (bus.req) begin
               // Anything other than a definite 1 on we falls through to a read
               if (bus.we) begin
                  w_mem_we    = 1'b1;
                  w_mem_addr  = bus.addr;
                  w_mem_wdata = bus.wdata;
               end else begin
                  w_mem_re     = 1'b1;
                  w_rvalid_nxt = 1'b1;
               end
            end
         end
         default: w_state_nxt = S_CLEAR;
      endcase
      w_ready_nxt     = (w_state_nxt == S_IDLE);
      w_init_done_nxt = r_init_done | w_ready_nxt;
   end

   // Storage array is never reset; the init sequence rewrites every word
   always_ff @(posedge clk) begin
      if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         r_rdata <= '0;
      else if (w_mem_re) r_rdata <= r_mem[bus.addr];
   end

   assign bus.ready     = r_ready;
   assign bus.init_done = r_init_done;
   assign bus.rvalid    = r_rvalid;
   assign bus.rdata     = r_rdata;
endmodule

// File: tb/tb_boot_sram.sv
// Bench for boot_sram: three configurations checked against a behavioural memory model.
module tb_boot_sram;
   localparam int unsigned DEPTH0 = 256;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   boot_sram_if #(.DATA_W(8),  .ADDR_W(8)) bus0 ();
   boot_sram_if #(.DATA_W(16), .ADDR_W(4)) bus1 ();
   boot_sram_if #(.DATA_W(8),  .ADDR_W(8)) bus2 ();

   boot_sram #(.DATA_W(8),  .ADDR_W(8), .BOOT_EN(1'b1), .BOOT_BASE(2)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
   boot_sram #(.DATA_W(16), .ADDR_W(4), .BOOT_EN(1'b1), .BOOT_BASE(2)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
   boot_sram #(.DATA_W(8),  .ADDR_W(8), .BOOT_EN(1'b0), .BOOT_BASE(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

   logic [7:0] boot_tbl [9] = '{8'h80, 8'h01, 8'h81, 8'h01, 8'h82, 8'h08, 8'h41, 8'h44, 8'h92};
   logic [7:0] model0 [DEPTH0];

   // Contents expected after a completed init of the default configuration
   task automatic model_init();
      for (int i = 0; i < int'(DEPTH0); i++) model0[i] = 8'h00;
      for (int k = 0; k < 9; k++) model0[2 + k] = boot_tbl[k];
   endtask

   function automatic logic [15:0] exp16(input int a);
      if (a >= 2 && a <= 10) return {8'h00, boot_tbl[a - 2]};
      return 16'h0000;
   endfunction

   task automatic drive_idle();
      bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;
      bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = '0; bus1.wdata = '0;
      bus2.req = 1'b0; bus2.we = 1'b0; bus2.addr = '0; bus2.wdata = '0;
   endtask

   task automatic test_reset();
      int n0, n1, n2;
      bit bad_rv;
      n0 = 0; n1 = 0; n2 = 0; bad_rv = 1'b0;
      drive_idle();
      reset = 1'b1;
      bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 8'h02; bus0.wdata = 8'h77;
      repeat (3) @(negedge clk);
      checks++; if (bus0.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus0.ready); end
      checks++; if (bus0.init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b expected 0", bus0.init_done); end
      checks++; if (bus0.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", bus0.rvalid); end
      checks++; if (bus0.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", bus0.rdata); end
      reset = 1'b0;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         if (bus0.rvalid !== 1'b0) bad_rv = 1'b1;
         if (n0 == 0 && bus0.ready === 1'b1) n0 = i;
         if (n1 == 0 && bus1.ready === 1'b1) n1 = i;
         if (n2 == 0 && bus2.ready === 1'b1) n2 = i;
         if (n0 != 0 && n1 != 0 && n2 != 0) break;
         bus0.we   = 1'($urandom_range(0, 1));
         bus0.addr = 8'($urandom);
      end
      drive_idle();
      checks++; if (n0 !== 265) begin errors++; $display("FAIL init_latency_default: got %0d expected 265", n0); end
      checks++; if (n1 !== 25) begin errors++; $display("FAIL init_latency_small: got %0d expected 25", n1); end
      checks++; if (n2 !== 256) begin errors++; $display("FAIL init_latency_noboot: got %0d expected 256", n2); end
      checks++; if (bad_rv !== 1'b0) begin errors++; $display("FAIL early_req_rvalid: got %b expected 0", bad_rv); end
      checks++; if (bus0.init_done !== 1'b1) begin errors++; $display("FAIL init_done: got %b expected 1", bus0.init_done); end
      model_init();
   endtask

   task automatic test_boot_reads();
      logic [7:0] addrs [4] = '{8'h02, 8'h0A, 8'h00, 8'hFF};
      for (int i = 0; i < 4; i++) begin
         bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = addrs[i];
         @(negedge clk);
         checks++; if (bus0.rvalid !== 1'b1) begin errors++; $display("FAIL boot_rd_rvalid[%h]: got %b expected 1", addrs[i], bus0.rvalid); end
         checks++; if (bus0.rdata !== model0[addrs[i]]) begin errors++; $display("FAIL boot_rd_data[%h]: got %h expected %h", addrs[i], bus0.rdata, model0[addrs[i]]); end
      end
      bus0.req = 1'b0;
      @(negedge clk);
      checks++; if (bus0.rvalid !== 1'b0) begin errors++; $display("FAIL boot_rd_idle_rvalid: got %b expected 0", bus0.rvalid); end
   endtask

   task automatic test_write_read();
      bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 8'h20; bus0.wdata = 8'h5A;
      model0[8'h20] = 8'h5A;
      @(negedge clk);
      checks++; if (bus0.rvalid !== 1'b0) begin errors++; $display("FAIL wr_rvalid: got %b expected 0", bus0.rvalid); end
      bus0.we = 1'b0;
      @(negedge clk);
      checks++; if (bus0.rvalid !== 1'b1) begin errors++; $display("FAIL wr_rd_rvalid: got %b expected 1", bus0.rvalid); end
      checks++; if (bus0.rdata !== model0[8'h20]) begin errors++; $display("FAIL wr_rd_data: got %h expected %h", bus0.rdata, model0[8'h20]); end
      bus0.req = 1'b0;
      @(negedge clk);
      checks++; if (bus0.rvalid !== 1'b0) begin errors++; $display("FAIL hold_rvalid: got %b expected 0", bus0.rvalid); end
      checks++; if (bus0.rdata !== 8'h5A) begin errors++; $display("FAIL hold_rdata: got %h expected 5a", bus0.rdata); end
   endtask

   task automatic test_random();
      logic [7:0] exp_rd;
      logic       exp_v;
      logic [7:0] a, d;
      int         op;
      exp_rd = 8'h00;
      for (int i = 0; i < 300; i++) begin
         op = (i == 0) ? 1 : int'($urandom_range(0, 2));
         a  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
         d  = 8'($urandom);
         bus0.req = (op != 0); bus0.we = (op == 2); bus0.addr = a; bus0.wdata = d;
         if (op == 1) begin exp_rd = model0[a]; exp_v = 1'b1; end
         else begin
            exp_v = 1'b0;
            if (op == 2) model0[a] = d;
         end
         @(negedge clk);
         checks++; if (bus0.rvalid !== exp_v) begin errors++; $display("FAIL rand_rvalid[%0d]: got %b expected %b", i, bus0.rvalid, exp_v); end
         checks++; if (bus0.rdata !== exp_rd) begin errors++; $display("FAIL rand_rdata[%0d]: got %h expected %h", i, bus0.rdata, exp_rd); end
      end
      bus0.req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_small_config();
      int a;
      for (int i = 0; i < 3; i++) begin
         a = (i == 0) ? 2 : (i == 1) ? 10 : 11;
         bus1.req = 1'b1; bus1.we = 1'b0; bus1.addr = 4'(a);
         @(negedge clk);
         checks++; if (bus1.rvalid !== 1'b1) begin errors++; $display("FAIL small_rvalid[%0d]: got %b expected 1", a, bus1.rvalid); end
         checks++; if (bus1.rdata !== exp16(a)) begin errors++; $display("FAIL small_rdata[%0d]: got %h expected %h", a, bus1.rdata, exp16(a)); end
      end
      bus1.req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_no_boot();
      logic [7:0] addrs [2] = '{8'h02, 8'h0A};
      for (int i = 0; i < 2; i++) begin
         bus2.req = 1'b1; bus2.we = 1'b0; bus2.addr = addrs[i];
         @(negedge clk);
         checks++; if (bus2.rvalid !== 1'b1) begin errors++; $display("FAIL noboot_rvalid[%h]: got %b expected 1", addrs[i], bus2.rvalid); end
         checks++; if (bus2.rdata !== 8'h00) begin errors++; $display("FAIL noboot_rdata[%h]: got %h expected 00", addrs[i], bus2.rdata); end
      end
      bus2.req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_load();
      int n;
      bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 8'h02; bus0.wdata = 8'hFF;
      @(negedge clk);
      bus0.we = 1'b0;
      @(negedge clk);
      checks++; if (bus0.rdata !== 8'hFF) begin errors++; $display("FAIL user_write: got %h expected ff", bus0.rdata); end
      #1 reset = 1'b1;
      #1;
      checks++; if (bus0.rvalid !== 1'b0) begin errors++; $display("FAIL async_rvalid_drop: got %b expected 0", bus0.rvalid); end
      checks++; if (bus0.ready !== 1'b0) begin errors++; $display("FAIL async_ready_drop: got %b expected 0", bus0.ready); end
      drive_idle();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (DEPTH0 + 4) @(negedge clk);
      checks++; if (bus0.ready !== 1'b0) begin errors++; $display("FAIL mid_load_ready: got %b expected 0", bus0.ready); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         if (bus0.ready === 1'b1) begin n = i; break; end
      end
      checks++; if (n !== 265) begin errors++; $display("FAIL reinit_latency: got %0d expected 265", n); end
      model_init();
      bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 8'h02;
      @(negedge clk);
      checks++; if (bus0.rdata !== model0[8'h02]) begin errors++; $display("FAIL reinit_boot: got %h expected %h", bus0.rdata, model0[8'h02]); end
      bus0.addr = 8'h20;
      @(negedge clk);
      checks++; if (bus0.rdata !== model0[8'h20]) begin errors++; $display("FAIL reinit_cleared: got %h expected %h", bus0.rdata, model0[8'h20]); end
      bus0.req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_boot_reads();
      test_write_read();
      test_random();
      test_small_config();
      test_no_boot();
      test_reset_mid_load();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
